// File: rtl/mmio_peripheral_unit_pkg.sv
// Shared register map, TCON bit positions and 7-segment glyph table for the MMIO peripheral block.
package periph_pkg;

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LED     = 3'd3,
        REG_DIGI    = 3'd4,
        REG_SYSTICK = 3'd5
    } reg_sel_e;

    localparam int TCON_EN     = 0;
    localparam int TCON_IE     = 1;
    localparam int TCON_STATUS = 2;

    // The register window is 32 bytes, so everything above bit 4 must match the base.
    localparam int WINDOW_LSB = 5;

    // Active-low g..a segment codes, entry i is the glyph for hex digit i.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/mmio_peripheral_unit_if.sv
// CPU data-bus port as seen by a memory-mapped peripheral.
interface mmio_peripheral_unit_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_peripheral_unit_hex_to_seg7.sv
// Hex nibble to active-low g..a 7-segment pattern.
module hex_to_seg7
    import periph_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG7_LUT[nibble_i];
endmodule

// File: rtl/mmio_peripheral_unit.sv
// Memory-mapped timer / LED / 7-segment scanner / cycle counter on the CPU data bus.
// Register reads are combinational; all state changes on the rising clock edge.
module mmio_peripheral_unit
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          TIMER_W     = 32,
    parameter int          LED_W       = 8,
    parameter int          DIGIT_COUNT = 4,
    parameter int          SCAN_DIV    = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_peripheral_unit_if.slave    bus,
    output logic [LED_W-1:0]         led,
    output logic [DIGIT_COUNT+7:0]   digi,
    output logic                     irq
);
    localparam int DV_W  = 4 * DIGIT_COUNT;
    localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
    localparam int PS_W  = $clog2(SCAN_DIV);

    logic [TIMER_W-1:0]     th_q, th_d, tl_q, tl_d;
    logic                   en_q, en_d, ie_q, ie_d, st_q, st_d;
    logic [LED_W-1:0]       led_q, led_d;
    logic [DV_W-1:0]        dv_q, dv_d;
    logic [31:0]            tick_q, tick_d;
    logic [PS_W-1:0]        ps_q, ps_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGIT_COUNT+7:0] digi_q, digi_d;

    logic        hit, wr_hit;
    logic [2:0]  word;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_dv;
    logic        run, reload, set_st, ps_last, idx_last;
    logic [31:0] rdata_c;
    logic [6:0]  seg;
    logic [3:0]  sel_nib;
    logic [DIGIT_COUNT-1:0] anode_n;
    logic [3:0]  nibbles [2**IDX_W];
    logic        unused_bits;

    assign hit     = bus.addr[31:WINDOW_LSB] == BASE_ADDR[31:WINDOW_LSB];
    assign word    = bus.addr[4:2];
    assign wr_hit  = bus.wr && hit;
    assign wr_th   = wr_hit && (word == REG_TH);
    assign wr_tl   = wr_hit && (word == REG_TL);
    assign wr_tcon = wr_hit && (word == REG_TCON);
    assign wr_led  = wr_hit && (word == REG_LED);
    assign wr_dv   = wr_hit && (word == REG_DIGI);

    // A TCON write that clears EN suppresses this cycle's count/reload as well.
    assign run    = en_q && !(wr_tcon && !bus.wdata[TCON_EN]);
    assign reload = run && (&tl_q);
    assign set_st = reload && ie_q;

    assign ps_last  = ps_q == PS_W'(SCAN_DIV - 1);
    assign idx_last = idx_q == IDX_W'(DIGIT_COUNT - 1);

    generate
        for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_nib
            if (gi < DIGIT_COUNT) begin : g_real
                assign nibbles[gi] = dv_q[4*gi +: 4];
            end else begin : g_pad
                assign nibbles[gi] = 4'h0;
            end
        end
        for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_anode
            assign anode_n[gi] = (idx_q != IDX_W'(gi));
        end
    endgenerate

    assign sel_nib = nibbles[idx_q];

    hex_to_seg7 u_seg (
        .nibble_i (sel_nib),
        .seg_o    (seg)
    );

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        st_d   = st_q;
        led_d  = led_q;
        dv_d   = dv_q;
        tick_d = tick_q + 32'd1;
        ps_d   = ps_q + PS_W'(1);
        idx_d  = idx_q;
        digi_d = digi_q;

        if (wr_th) th_d = bus.wdata[TIMER_W-1:0];

        // Bus write to TL takes priority over the counter.
        if (wr_tl)       tl_d = bus.wdata[TIMER_W-1:0];
        else if (reload) tl_d = th_q;
        else if (run)    tl_d = tl_q + TIMER_W'(1);

        if (wr_tcon) begin
            en_d = bus.wdata[TCON_EN];
            ie_d = bus.wdata[TCON_IE];
        end

        // A reload setting STATUS beats a simultaneous write-one-to-clear.
        if (set_st)                                  st_d = 1'b1;
        else if (wr_tcon && bus.wdata[TCON_STATUS])  st_d = 1'b0;

        if (wr_led) led_d = bus.wdata[LED_W-1:0];
        if (wr_dv)  dv_d  = bus.wdata[DV_W-1:0];

        if (ps_last) begin
            ps_d   = '0;
            idx_d  = idx_last ? '0 : idx_q + IDX_W'(1);
            digi_d = {anode_n, 1'b1, seg};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            st_q   <= 1'b0;
            led_q  <= '0;
            dv_q   <= '0;
            tick_q <= '0;
            ps_q   <= '0;
            idx_q  <= '0;
            digi_q <= '1;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            st_q   <= st_d;
            led_q  <= led_d;
            dv_q   <= dv_d;
            tick_q <= tick_d;
            ps_q   <= ps_d;
            idx_q  <= idx_d;
            digi_q <= digi_d;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (bus.rd && hit) begin
            case (word)
                REG_TH:      rdata_c = 32'(th_q);
                REG_TL:      rdata_c = 32'(tl_q);
                REG_TCON:    rdata_c = {29'b0, st_q, ie_q, en_q};
                REG_LED:     rdata_c = 32'(led_q);
                REG_DIGI:    rdata_c = 32'(dv_q);
                REG_SYSTICK: rdata_c = tick_q;
                default:     rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;
    assign led       = led_q;
    assign digi      = digi_q;
    assign irq       = st_q & ie_q;

    // Byte-lane bits and wide write-data bits beyond narrow registers carry no meaning here.
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

endmodule

// File: tb/tb_mmio_peripheral_unit.sv
// Randomised bench for mmio_peripheral_unit: a register-level model is checked every cycle,
// with directed sequences pinning timer, scanner, decode and async-reset behaviour to literals.
module tb_mmio_peripheral_unit;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int SD = 4;
    localparam int DC = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    mmio_peripheral_unit_if bus ();

    mmio_peripheral_unit #(
        .BASE_ADDR   (BASE),
        .TIMER_W     (32),
        .LED_W       (8),
        .DIGIT_COUNT (DC),
        .SCAN_DIV    (SD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .digi  (digi),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_th = '0, m_tl = '0, m_tick = '0;
    logic        m_en = 1'b0, m_ie = 1'b0, m_st = 1'b0;
    logic [7:0]  m_led = '0;
    logic [15:0] m_dv = '0, m_old_dv;
    logic [11:0] m_digi = 12'hFFF;
    int          m_n = 0;
    int          m_d;
    bit          m_hw, m_run, m_wrap;
    logic [2:0]  m_off;
    logic [31:0] m_wd;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_th = '0; m_tl = '0; m_tick = '0; m_en = 0; m_ie = 0; m_st = 0;
            m_led = '0; m_dv = '0; m_digi = 12'hFFF; m_n = 0;
        end else begin
            m_hw     = bus.wr && (bus.addr[31:5] == BASE[31:5]);
            m_off    = bus.addr[4:2];
            m_wd     = bus.wdata;
            m_old_dv = m_dv;
            m_run    = m_en && !(m_hw && m_off == 3'd2 && !m_wd[0]);
            m_wrap   = m_run && (m_tl == 32'hFFFF_FFFF);
            if (m_hw && m_off == 3'd1) m_tl = m_wd;
            else if (m_wrap)           m_tl = m_th;
            else if (m_run)            m_tl = m_tl + 1;
            if (m_wrap && m_ie)                        m_st = 1'b1;
            else if (m_hw && m_off == 3'd2 && m_wd[2]) m_st = 1'b0;
            if (m_hw && m_off == 3'd2) begin m_en = m_wd[0]; m_ie = m_wd[1]; end
            if (m_hw && m_off == 3'd0) m_th  = m_wd;
            if (m_hw && m_off == 3'd3) m_led = m_wd[7:0];
            if (m_hw && m_off == 3'd4) m_dv  = m_wd[15:0];
            m_tick = m_tick + 1;
            m_n    = m_n + 1;
            // Slot k (k>=1) ends at cycle k*SD after reset and shows digit (k-1) mod DC.
            if (m_n % SD == 0) begin
                m_d    = (m_n / SD - 1) % DC;
                m_digi = {~(4'b0001 << m_d), 1'b1, seg7(m_old_dv[4*m_d +: 4])};
            end
        end
    end

    function automatic logic [31:0] exp_rdata();
        if (!bus.rd || bus.addr[31:5] != BASE[31:5]) return 32'h0;
        case (bus.addr[4:2])
            3'd0:    return m_th;
            3'd1:    return m_tl;
            3'd2:    return {29'b0, m_st, m_ie, m_en};
            3'd3:    return {24'b0, m_led};
            3'd4:    return {16'b0, m_dv};
            3'd5:    return m_tick;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        check("cyc_led",   {24'b0, led},  {24'b0, m_led});
        check("cyc_digi",  {20'b0, digi}, {20'b0, m_digi});
        check("cyc_irq",   {31'b0, irq},  {31'b0, m_st & m_ie});
        check("cyc_rdata", bus.rdata,     exp_rdata());
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr = 1'b0;
        $display("[TB] write addr=%08h data=%08h", a, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.wr = 1'b0; bus.rd = 1'b1; bus.addr = a;
        #1;
        check(name, bus.rdata, exp);
    endtask

    logic [11:0] scan_tab [4] = '{12'hEC0, 12'hDF9, 12'hBA4, 12'h7B0};
    logic [31:0] t1, r, off;

    initial begin
        bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
        #1 reset = 1'b0;

        // Reset with bus noise
        repeat (5) begin
            @(negedge clk);
            r = $urandom;
            bus.wr = r[0]; bus.rd = 1'b1;
            bus.addr = BASE + {27'b0, r[4:2], 2'b00}; bus.wdata = $urandom;
        end
        bus.wr = 0;
        check("rst_led",  {24'b0, led},  32'h0);
        check("rst_digi", {20'b0, digi}, 32'hFFF);
        check("rst_irq",  {31'b0, irq},  32'h0);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", BASE + 32'(4 * i), 32'h0);

        // Scanner: release, load 0x3210 before the first slot boundary
        @(negedge clk);
        bus.rd = 0;
        reset = 1'b1;
        bus_write(BASE + 32'h10, 32'h0000_3210);
        @(negedge clk);
        check("scan_blank", {20'b0, digi}, 32'hFFF);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("scan_digi", {20'b0, digi}, {20'b0, scan_tab[(k / 4) % 4]});
        end

        // Bus decode
        bus_write(BASE + 32'h0C, 32'hA5);
        check("dec_led", {24'b0, led}, 32'hA5);
        rd_chk("dec_led_rd", BASE + 32'h0C, 32'hA5);
        t1 = bus.rdata;
        rd_chk("systick_pre", BASE + 32'h14, m_tick);
        t1 = bus.rdata;
        bus_write(BASE + 32'h14, 32'h0);
        rd_chk("systick_ro", BASE + 32'h14, t1 + 32'd2);
        rd_chk("dec_1c",   BASE + 32'h1C, 32'h0);
        rd_chk("dec_20",   BASE + 32'h20, 32'h0);
        rd_chk("dec_miss", 32'h5000_000C, 32'h0);
        bus.rd = 0; bus.addr = BASE + 32'h0C; #1;
        check("dec_rd0", bus.rdata, 32'h0);

        // Timer overflow
        bus_write(BASE + 32'h00, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
        bus_write(BASE + 32'h08, 32'h3);
        rd_chk("tl_start", BASE + 32'h04, 32'hFFFF_FFFD);
        @(negedge clk); rd_chk("tl_fe", BASE + 32'h04, 32'hFFFF_FFFE);
        @(negedge clk); rd_chk("tl_ff", BASE + 32'h04, 32'hFFFF_FFFF);
        check("irq_pre", {31'b0, irq}, 32'h0);
        @(negedge clk); rd_chk("tl_reload", BASE + 32'h04, 32'hFFFF_FFFD);
        check("irq_set", {31'b0, irq}, 32'h1);
        rd_chk("tcon_set", BASE + 32'h08, 32'h7);
        @(negedge clk);
        bus.rd = 0; bus.wr = 1; bus.addr = BASE + 32'h08; bus.wdata = 32'h7;
        @(negedge clk);
        bus.wr = 0;
        check("irq_clr", {31'b0, irq}, 32'h0);
        rd_chk("tl_ff2", BASE + 32'h04, 32'hFFFF_FFFF);
        // Clear collides with the reload edge
        bus.rd = 0; bus.wr = 1; bus.addr = BASE + 32'h08; bus.wdata = 32'h7;
        @(negedge clk);
        bus.wr = 0;
        check("irq_collide", {31'b0, irq}, 32'h1);
        rd_chk("tl_collide", BASE + 32'h04, 32'hFFFF_FFFD);
        rd_chk("tcon_collide", BASE + 32'h08, 32'h7);
        // Disable exactly in an overflow cycle
        @(negedge clk);
        @(negedge clk); rd_chk("tl_ff3", BASE + 32'h04, 32'hFFFF_FFFF);
        bus.rd = 0; bus.wr = 1; bus.addr = BASE + 32'h08; bus.wdata = 32'h2;
        @(negedge clk);
        rd_chk("tl_hold", BASE + 32'h04, 32'hFFFF_FFFF);
        check("irq_hold", {31'b0, irq}, 32'h1);
        rd_chk("tcon_dis", BASE + 32'h08, 32'h6);
        @(negedge clk); rd_chk("tl_hold2", BASE + 32'h04, 32'hFFFF_FFFF);

        // Async reset between edges
        bus_write(BASE + 32'h08, 32'h3);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_irq",  {31'b0, irq},  32'h0);
        check("arst_led",  {24'b0, led},  32'h0);
        check("arst_digi", {20'b0, digi}, 32'hFFF);
        rd_chk("arst_tl", BASE + 32'h04, 32'h0);
        repeat (3) begin
            @(negedge clk);
            r = $urandom;
            bus.wr = r[0]; bus.rd = r[1];
            bus.addr = BASE + {27'b0, r[4:2], 2'b00}; bus.wdata = $urandom;
        end
        @(negedge clk);
        bus.wr = 0; bus.rd = 0;
        reset = 1'b1;

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = $urandom;
            if (!reset) reset = 1'b1;
            else if (r[31:23] == 9'd0) reset = 1'b0;
            bus.wr = (r[1:0] == 2'b00);
            bus.rd = r[2];
            off = {29'b0, r[7:5]};
            if (r[11:8] == 4'd0) bus.addr = $urandom;
            else                 bus.addr = BASE + {27'b0, off[2:0], r[13:12]};
            if ((off == 0 || off == 1) && r[14]) bus.wdata = 32'hFFFF_FFF0 | {28'b0, r[18:15]};
            else if (off == 2)                   bus.wdata = {29'b0, r[17:16], r[18] | r[19]};
            else                                 bus.wdata = $urandom;
        end
        @(negedge clk);
        bus.wr = 0; bus.rd = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_peripheral_unit.md
# mmio_peripheral_unit

Memory-mapped peripheral block on the single-cycle CPU's data bus, decoded next to data memory. It provides a reloadable interval timer that drives the CPU interrupt request, an LED register, a multiplexed 7-segment display scanner and a free-running cycle counter. It generalises the fixed 8-LED / 4-digit outputs to parametrised widths and digit counts, and adds autonomous timer and scan sequencing.

## Interface

Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the 32-byte register window
- TIMER_W, 32, timer width (1..32); narrower registers are zero-extended on read
- LED_W, 8, LED register width (1..32)
- DIGIT_COUNT, 4, number of multiplexed digits (1..8)
- SCAN_DIV, 50000, clock cycles per digit slot (≥2)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low
- rd  in  1  bus read strobe (CPU MemRd)
- wr  in  1  bus write strobe (CPU MemWr), sampled on rising clk
- addr  in  32  byte address (CPU ALU result)
- wdata  in  32  write data (CPU register-file port B)
- rdata  out  32  read data, combinational
- led  out  LED_W  LED register contents
- digi  out  DIGIT_COUNT+8  {anodes one-hot active-low, dp, g..a active-low}
- irq  out  1  timer interrupt request to Control

## Operation

- Hit when addr[31:5]==BASE_ADDR[31:5]; addr[1:0] ignored.
- Word offsets: 0x00 TH (reload), 0x04 TL (count), 0x08 TCON, 0x0C LED, 0x10 DIGI_VAL (4 bits per digit, digit 0 in [3:0]), 0x14 SYSTICK (read-only; writes ignored). 0x18/0x1C and misses read 0.
- TCON: bit0 EN, bit1 IE, bit2 STATUS. A write updates EN/IE; writing 1 to bit2 clears STATUS; writing 0 leaves it. Reads return {29'b0,STATUS,IE,EN}.
- Timer: while EN=1, each cycle TL==all-ones → TL←TH, and STATUS←1 if IE=1; otherwise TL←TL+1. EN=0 holds TL.
- irq = STATUS & IE.
- SYSTICK increments every cycle, 32-bit, wraps to 0.
- Scanner: prescaler counts 0..SCAN_DIV-1. On terminal count the digit index advances 0..DIGIT_COUNT-1 and wraps to 0. digi is loaded with the anode pattern for that index (active digit low) and the hex-decoded nibble. dp is always 1.
- rdata = 0 when rd=0 or on a miss.

## Timing

- Reset (reset=0, asynchronous): TH, TL, TCON, led, DIGI_VAL, SYSTICK, prescaler and digit index = 0; digi = all ones (blank); irq = 0.
- Writes take effect at the rising edge where wr=1 and the address hits. Reads are zero-latency combinational.
- Write to TL in the same cycle as a count or reload: the bus value wins.
- TCON write clearing STATUS in the same cycle as a reload setting it: the set wins, so STATUS=1.
- TCON write of EN=0 in an overflow cycle: the write wins, no reload, STATUS unchanged.
- irq rises the cycle after the edge that reloads TL. It falls the cycle after the clearing write edge.
- First digi update occurs SCAN_DIV cycles after reset release and shows digit 0. Each slot lasts exactly SCAN_DIV cycles.
- A DIGI_VAL write is visible on digi at the next slot boundary, not immediately.
- Reset asserted mid-operation: all state is forced to reset values immediately, without waiting for a clock edge.

## Structure

- Package periph_pkg: register offsets, TCON bit indices (EN=0, IE=1, STATUS=2), 7-segment code constants.
- Sub-module hex_to_seg7: 4-bit nibble in, 7-bit active-low g..a out, combinational. It is instantiated once on the selected nibble.

## Test plan

- Reset: drive reset=0 with random bus activity → led=0, digi=all ones, irq=0, every register reads 0.
- Timer overflow: TH=TL=0xFFFF_FFFD, then TCON=3 → TL reads FE, FF, then FD. STATUS=1 and irq=1 from the cycle after the reload. A TCON write of 0x7 clears irq on the next cycle.
- Set/clear collision: TCON write 0x7 in the same cycle TL reloads → STATUS stays 1, irq stays 1.
- Scanner (SCAN_DIV=4, DIGIT_COUNT=4): DIGI_VAL=0x3210 → digi = {1110,C0}, {1101,F9}, {1011,A4}, {0111,B0}, each for 4 cycles, then wrap to digit 0.
- Bus decode: write 0xA5 to BASE+0x0C → led=0xA5. Write to BASE+0x14 → SYSTICK unaffected. Read BASE+0x1C and BASE+0x20 → 0. rd=0 → rdata=0.
- Async reset mid-count: assert reset between clock edges → TL=0 and irq=0 before the next edge.
